// File: rtl/dcache_bus_arbiter_if.sv
// Bus bundle between the two D-cache requesters, the arbiter and the D-cache.
// Request format {addr[65:34], wdata[33:2], rd[1], wr[0]}; response format {miss[32], rdata[31:0]}.
interface dcache_bus_arbiter_if #(
    parameter int CNT_W = 16
);
    logic [65:0]        i_p0_bus;
    logic [32:0]        o_p0_bus;
    logic [65:0]        i_p1_bus;
    logic [32:0]        o_p1_bus;
    logic [65:0]        o_dc_bus;
    logic [32:0]        i_dc_bus;
    logic [1:0]         o_owner;
    logic               o_p1_prio;
    logic [3*CNT_W-1:0] o_stats;

    modport slave (
        input  i_p0_bus, i_p1_bus, i_dc_bus,
        output o_p0_bus, o_p1_bus, o_dc_bus, o_owner, o_p1_prio, o_stats
    );

    modport master (
        output i_p0_bus, i_p1_bus, i_dc_bus,
        input  o_p0_bus, o_p1_bus, o_dc_bus, o_owner, o_p1_prio, o_stats
    );
endinterface

// File: rtl/dcache_bus_arbiter.sv
// Two-port D-cache bus arbiter: port 0 (MA stage) has priority, port 1 gains it after MAX_WAIT lost cycles.
// Optional statistics counters are built only when DCARB_STATS_EN is defined.
module dcache_bus_arbiter #(
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    dcache_bus_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_e;

    localparam logic [1:0]  OWN_NONE = 2'b00;
    localparam logic [1:0]  OWN_P0   = 2'b01;
    localparam logic [1:0]  OWN_P1   = 2'b10;
    localparam logic [32:0] STALL    = {1'b1, 32'h0};
    localparam logic [7:0]  WAIT_MAX = 8'(MAX_WAIT);

    state_e      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic        prio_q, prio_d;
    logic        req0, req1, dc_miss;
    logic [1:0]  owner;

    // An illegal rd+wr request is forwarded as a plain read.
    function automatic logic [65:0] sanitize(input logic [65:0] b);
        return {b[65:2], b[1], b[0] & ~b[1]};
    endfunction

    assign req0    = bus.i_p0_bus[1] | bus.i_p0_bus[0];
    assign req1    = bus.i_p1_bus[1] | bus.i_p1_bus[0];
    assign dc_miss = bus.i_dc_bus[32];

    always_comb begin
        state_d = state_q;
        owner   = OWN_NONE;
        case (state_q)
            IDLE: begin
                if (req1 && (prio_q || !req0)) owner = OWN_P1;
                else if (req0)                 owner = OWN_P0;
                if (dc_miss && owner == OWN_P0) state_d = BUSY0;
                if (dc_miss && owner == OWN_P1) state_d = BUSY1;
            end
            BUSY0: begin
                owner = OWN_P0;
                if (!dc_miss) state_d = IDLE;
            end
            BUSY1: begin
                owner = OWN_P1;
                if (!dc_miss) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wait_d = wait_q;
        if (!req1 || owner == OWN_P1) wait_d = 8'd0;
        else if (wait_q != WAIT_MAX)  wait_d = wait_q + 8'd1;
        prio_d = (wait_d == WAIT_MAX);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wait_q  <= 8'd0;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            prio_q  <= prio_d;
        end
    end

    // Every output is held at zero while reset is asserted, even mid-transaction.
    always_comb begin
        bus.o_dc_bus  = 66'h0;
        bus.o_p0_bus  = 33'h0;
        bus.o_p1_bus  = 33'h0;
        bus.o_owner   = OWN_NONE;
        bus.o_p1_prio = 1'b0;
        if (rst) begin
            bus.o_owner   = owner;
            bus.o_p1_prio = prio_q;
            if (owner == OWN_P0)      bus.o_dc_bus = sanitize(bus.i_p0_bus);
            else if (owner == OWN_P1) bus.o_dc_bus = sanitize(bus.i_p1_bus);
            if (owner == OWN_P0) bus.o_p0_bus = bus.i_dc_bus;
            else if (req0)       bus.o_p0_bus = STALL;
            if (owner == OWN_P1) bus.o_p1_bus = bus.i_dc_bus;
            else if (req1)       bus.o_p1_bus = STALL;
        end
    end

`ifdef DCARB_STATS_EN
    localparam logic [CNT_W-1:0] ONE = 1;
    logic [CNT_W-1:0] p0_cnt_q, p1_cnt_q, conf_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p0_cnt_q   <= '0;
            p1_cnt_q   <= '0;
            conf_cnt_q <= '0;
        end else begin
            if (state_q == IDLE && owner == OWN_P0) p0_cnt_q <= p0_cnt_q + ONE;
            if (state_q == IDLE && owner == OWN_P1) p1_cnt_q <= p1_cnt_q + ONE;
            if (req0 && req1)                       conf_cnt_q <= conf_cnt_q + ONE;
        end
    end

    assign bus.o_stats = {p0_cnt_q, p1_cnt_q, conf_cnt_q};
`else
    assign bus.o_stats = {(3*CNT_W){1'b0}};
`endif
endmodule

// File: tb/tb_dcache_bus_arbiter.sv
// Scoreboard bench for dcache_bus_arbiter: expectations are queued as stimulus is applied and
// checked at the following falling edge; build with +define+DCARB_STATS_EN to check the counters.
module tb_dcache_bus_arbiter;
    localparam int CNT_W = 16;
    localparam logic [1:0]  O_NONE = 2'b00;
    localparam logic [1:0]  O_P0   = 2'b01;
    localparam logic [1:0]  O_P1   = 2'b10;
    localparam logic [32:0] STALL  = {1'b1, 32'h0};
    localparam logic [32:0] Z33    = 33'h0;
    localparam logic [65:0] Z66    = 66'h0;

    typedef struct packed {
        logic [1:0]  owner;
        logic [65:0] dc;
        logic [32:0] r0;
        logic [32:0] r1;
        logic        prio;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_run  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    dcache_bus_arbiter_if #(.CNT_W(CNT_W)) bus();

    dcache_bus_arbiter #(.MAX_WAIT(8), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [65:0] rq(input logic [31:0] a, input logic [31:0] d,
                                       input logic rd, input logic wr);
        return {a, d, rd, wr};
    endfunction

    function automatic string fmt(input exp_t x);
        return $sformatf("own=%b dc=%h r0=%h r1=%h prio=%b", x.owner, x.dc, x.r0, x.r1, x.prio);
    endfunction

    task automatic drive(input logic [65:0] p0, input logic [65:0] p1, input logic [32:0] dc,
                         input logic [1:0] own, input logic [65:0] edc,
                         input logic [32:0] e0, input logic [32:0] e1, input logic ep);
        exp_t x;
        bus.i_p0_bus = p0;
        bus.i_p1_bus = p1;
        bus.i_dc_bus = dc;
        x = '{own, edc, e0, e1, ep};
        sb.push_back(x);
    endtask

    task automatic observe(output exp_t got, output exp_t e);
        @(negedge clk);
        e   = sb.pop_front();
        got = '{bus.o_owner, bus.o_dc_bus, bus.o_p0_bus, bus.o_p1_bus, bus.o_p1_prio};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t got, e;
        logic [65:0] p0, p1;
        p0 = rq(32'h100, 32'h0, 1'b1, 1'b0);
        p1 = rq(32'h200, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                rst = 1'b0;
                drive(p0, p1, {1'b1, 32'h1234}, O_NONE, Z66, Z33, Z33, 1'b0);
            end else begin
                rst = 1'b1;
                drive(Z66, Z66, Z33, O_NONE, Z66, Z33, Z33, 1'b0);
            end
            observe(got, e);
            n_run++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %s, want %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_hit();
        exp_t got, e;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: drive(rq(32'h100, 32'h0, 1'b1, 1'b0), Z66, {1'b0, 32'hCAFEF00D},
                         O_P0, rq(32'h100, 32'h0, 1'b1, 1'b0), {1'b0, 32'hCAFEF00D}, Z33, 1'b0);
                1: drive(rq(32'h104, 32'h99, 1'b1, 1'b1), Z66, {1'b0, 32'h11},
                         O_P0, rq(32'h104, 32'h99, 1'b1, 1'b0), {1'b0, 32'h11}, Z33, 1'b0);
                default: drive(Z66, rq(32'h200, 32'h0, 1'b1, 1'b0), {1'b0, 32'h22},
                         O_P1, rq(32'h200, 32'h0, 1'b1, 1'b0), Z33, {1'b0, 32'h22}, 1'b0);
            endcase
            observe(got, e);
            n_run++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL hit[%0d]: got %s, want %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_miss_lock();
        exp_t got, e;
        logic [65:0] w, r;
        w = rq(32'h300, 32'h55, 1'b0, 1'b1);
        r = rq(32'h400, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            case (i)
                0:       drive(w, Z66, STALL, O_P0, w, STALL, Z33, 1'b0);
                1, 2:    drive(w, r, STALL, O_P0, w, STALL, STALL, 1'b0);
                3:       drive(w, r, Z33, O_P0, w, Z33, STALL, 1'b0);
                default: drive(Z66, r, {1'b0, 32'hBEEF}, O_P1, r, Z33, {1'b0, 32'hBEEF}, 1'b0);
            endcase
            observe(got, e);
            n_run++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL miss_lock[%0d]: got %s, want %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_starvation();
        exp_t got, e;
        logic [65:0] p0, p1;
        logic [32:0] d;
        p0 = rq(32'h600, 32'h0, 1'b1, 1'b0);
        p1 = rq(32'h700, 32'h0, 1'b1, 1'b0);
        for (int k = 1; k <= 11; k++) begin
            d = {1'b0, 32'h1000 + 32'(k)};
            if (k == 9) drive(p0, p1, d, O_P1, p1, STALL, d, 1'b1);
            else        drive(p0, p1, d, O_P0, p0, d, STALL, 1'b0);
            observe(got, e);
            n_run++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL starvation[%0d]: got %s, want %s", k, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_reset_mid_busy1();
        exp_t got, e;
        logic [65:0] p0, p1;
        p0 = rq(32'h510, 32'h0, 1'b1, 1'b0);
        p1 = rq(32'h500, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: drive(Z66, p1, STALL, O_P1, p1, Z33, STALL, 1'b0);
                1: drive(p0, p1, STALL, O_P1, p1, STALL, STALL, 1'b0);
                2: begin
                    rst = 1'b0;
                    drive(p0, p1, STALL, O_NONE, Z66, Z33, Z33, 1'b0);
                end
                default: begin
                    rst = 1'b1;
                    drive(p0, p1, {1'b0, 32'h77}, O_P0, p0, {1'b0, 32'h77}, STALL, 1'b0);
                end
            endcase
            observe(got, e);
            n_run++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset_busy1[%0d]: got %s, want %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_stats();
        exp_t got, e;
        logic [65:0] p0, p1;
        logic [3*CNT_W-1:0] want;
        p0 = rq(32'h800, 32'h0, 1'b1, 1'b0);
        p1 = rq(32'h900, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            case (i)
                0: begin
                    rst = 1'b0;
                    drive(Z66, Z66, Z33, O_NONE, Z66, Z33, Z33, 1'b0);
                end
                1, 2, 3: begin
                    rst = 1'b1;
                    drive(p0, p1, {1'b0, 32'h5}, O_P0, p0, {1'b0, 32'h5}, STALL, 1'b0);
                end
                4, 5:    drive(p0, Z66, {1'b0, 32'h6}, O_P0, p0, {1'b0, 32'h6}, Z33, 1'b0);
                6, 7:    drive(Z66, p1, {1'b0, 32'h7}, O_P1, p1, Z33, {1'b0, 32'h7}, 1'b0);
                default: drive(Z66, Z66, Z33, O_NONE, Z66, Z33, Z33, 1'b0);
            endcase
            observe(got, e);
            n_run++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL stats_traffic[%0d]: got %s, want %s", i, fmt(got), fmt(e));
            end
        end
`ifdef DCARB_STATS_EN
        want = {16'd5, 16'd2, 16'd3};
`else
        want = '0;
`endif
        n_run++;
        if (bus.o_stats !== want) begin
            n_fail++;
            $display("FAIL stats: got %h, want %h", bus.o_stats, want);
        end
    endtask

    initial begin
        bus.i_p0_bus = Z66;
        bus.i_p1_bus = Z66;
        bus.i_dc_bus = Z33;
        #2;
        test_reset();
        test_hit();
        test_miss_lock();
        test_starvation();
        test_reset_mid_busy1();
        test_stats();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
